// File: rtl/ddr_rd_stream.sv
// DDR read streamer: splits a contiguous beat transfer into 4 KB-safe bursts,
// issues them on FIFO credit and replays the returned beats as a valid/ready stream.
module ddr_rd_stream #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned MAX_BURST  = 16,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter int unsigned DDR_W      = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              done,
  input  logic [ADDR_W-1:0] conf_base_addr,
  input  logic [15:0]       conf_beat_num,
  output logic [ADDR_W-1:0] rd_req_addr,
  output logic [7:0]        rd_req_len,
  output logic              rd_req_valid,
  input  logic              rd_req_ready,
  input  logic [DDR_W-1:0]  rd_data,
  input  logic              rd_data_valid,
  output logic              rd_data_ready,
  output logic [DDR_W-1:0]  ddr_data,
  output logic              ddr_valid,
  input  logic              ddr_ready
);

  localparam int unsigned BEAT_B  = DDR_W / 8;
  localparam int unsigned BEAT_SH = $clog2(BEAT_B);
  localparam int unsigned RW      = 17;
  localparam int unsigned PW      = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW    = PW + 1;
  localparam int unsigned CW      = PW + 2;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [RW-1:0]     req_rem_q;
  logic [RW-1:0]     out_rem_q;
  logic [CW-1:0]     cred_q;
  logic              req_valid_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [7:0]        req_len_q;
  logic [RW-1:0]     req_burst_q;
  logic              done_q;

  logic [DDR_W-1:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q;
  logic [PW-1:0]     rd_ptr_q;
  logic [CNTW-1:0]   cnt_q;
  logic [DDR_W-1:0]  dout_q;
  logic              dvalid_q;

  logic              req_acc;
  logic              out_hs;
  logic              fifo_wr;
  logic              out_free;
  logic              pop_mem;
  logic              bypass;
  logic              push_mem;
  logic [RW-1:0]     bnd_room;
  logic [RW-1:0]     burst_len;
  logic              credit_ok;

  assign req_acc  = req_valid_q && rd_req_ready;
  assign out_hs   = dvalid_q && ddr_ready;
  assign fifo_wr  = rd_data_valid && (state_q != S_IDLE);
  assign out_free = !dvalid_q || ddr_ready;
  assign pop_mem  = out_free && (cnt_q != CNTW'(0));
  // An empty FIFO lets a fresh beat go straight into the output register.
  assign bypass   = out_free && (cnt_q == CNTW'(0)) && fifo_wr;
  assign push_mem = fifo_wr && !bypass;

  assign done          = done_q;
  assign rd_req_addr   = req_addr_q;
  assign rd_req_len    = req_len_q;
  assign rd_req_valid  = req_valid_q;
  assign rd_data_ready = 1'b1;
  assign ddr_data      = dout_q;
  assign ddr_valid     = dvalid_q;

  // Next burst size: capped by MAX_BURST, remaining beats and distance to the 4 KB page end.
  always_comb begin
    bnd_room  = RW'((13'h1000 - {1'b0, addr_q[11:0]}) >> BEAT_SH);
    burst_len = RW'(MAX_BURST);
    if (req_rem_q < burst_len) burst_len = req_rem_q;
    if (bnd_room < burst_len)  burst_len = bnd_room;
    credit_ok = (RW'(cred_q) + burst_len) <= RW'(FIFO_DEPTH);
  end

  // Control FSM, request channel, credit and remaining-beat counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      req_rem_q   <= '0;
      out_rem_q   <= '0;
      cred_q      <= '0;
      req_valid_q <= 1'b0;
      req_addr_q  <= '0;
      req_len_q   <= '0;
      req_burst_q <= '0;
      done_q      <= 1'b1;
    end else begin
      cred_q <= cred_q + (req_acc ? CW'(req_burst_q) : CW'(0))
                       - (out_hs ? CW'(1) : CW'(0));
      if (out_hs) out_rem_q <= out_rem_q - RW'(1);

      case (state_q)
        S_IDLE: begin
          if (start) begin
            addr_q    <= conf_base_addr;
            req_rem_q <= RW'(conf_beat_num) + RW'(1);
            out_rem_q <= RW'(conf_beat_num) + RW'(1);
            done_q    <= 1'b0;
            state_q   <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (req_acc) begin
            req_valid_q <= 1'b0;
            addr_q      <= addr_q + (ADDR_W'(req_burst_q) << BEAT_SH);
            req_rem_q   <= req_rem_q - req_burst_q;
            if (req_rem_q == req_burst_q) state_q <= S_DRAIN;
          end else if (!req_valid_q && credit_ok) begin
            req_valid_q <= 1'b1;
            req_addr_q  <= addr_q;
            req_len_q   <= 8'(burst_len - RW'(1));
            req_burst_q <= burst_len;
          end
        end
        S_DRAIN: begin
          if (out_hs && (out_rem_q == RW'(1))) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // FIFO pointers, occupancy and the first-word-fall-through output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      if (push_mem) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop_mem)  rd_ptr_q <= rd_ptr_q + PW'(1);
      cnt_q <= cnt_q + CNTW'(push_mem) - CNTW'(pop_mem);
      if (pop_mem) begin
        dout_q   <= mem_q[rd_ptr_q];
        dvalid_q <= 1'b1;
      end else if (bypass) begin
        dout_q   <= rd_data;
        dvalid_q <= 1'b1;
      end else if (out_hs) begin
        dvalid_q <= 1'b0;
      end
    end
  end

  // FIFO storage; needs no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_mem) mem_q[wr_ptr_q] <= rd_data;
  end

  // Credit should make overflow unreachable; flag it if a beat lands on a full FIFO.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push_mem && !pop_mem && (cnt_q == CNTW'(FIFO_DEPTH))))
        else $error("ddr_rd_stream: read beat arrived with FIFO full");
    end
  end

endmodule

// File: tb/tb_ddr_rd_stream.sv
// Directed bench for ddr_rd_stream: in-order DDR responder, stream sink, hand-computed bursts.
`timescale 1ns/1ps
module tb_ddr_rd_stream;

  localparam int unsigned DW = 512;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          done;
  logic [31:0]   conf_base_addr;
  logic [15:0]   conf_beat_num;
  logic [31:0]   rd_req_addr;
  logic [7:0]    rd_req_len;
  logic          rd_req_valid;
  logic          rd_req_ready;
  logic [DW-1:0] rd_data;
  logic          rd_data_valid;
  logic          rd_data_ready;
  logic [DW-1:0] ddr_data;
  logic          ddr_valid;
  logic          ddr_ready;

  ddr_rd_stream #(.ADDR_W(32), .MAX_BURST(16), .FIFO_DEPTH(64), .DDR_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .conf_base_addr(conf_base_addr), .conf_beat_num(conf_beat_num),
    .rd_req_addr(rd_req_addr), .rd_req_len(rd_req_len),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_data(rd_data), .rd_data_valid(rd_data_valid), .rd_data_ready(rd_data_ready),
    .ddr_data(ddr_data), .ddr_valid(ddr_valid), .ddr_ready(ddr_ready)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit rst_nx = 1'b0, start_nx = 1'b0, rq_ready_v = 1'b1, sink_ready_v = 1'b1;
  logic [31:0] exp_base = '0;
  int exp_total = 0, rcv = 0, cred_m = 0, req_beats = 0, last_hs_cyc = -10;
  logic [31:0] req_addr_log[$];
  logic [7:0]  req_len_log[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  bit p_rst = 1'b1, p_rqv = 1'b0, p_rqr = 1'b0, p_dv = 1'b0, p_dr = 1'b0;
  logic [31:0]   p_addr = '0;
  logic [7:0]    p_len = '0;
  logic [DW-1:0] p_data = '0;

  // Memory content: every beat is a pattern derived from its byte address.
  function automatic logic [DW-1:0] data_for(input logic [31:0] a);
    logic [DW-1:0] d;
    for (int k = 0; k < int'(DW / 32); k++) d[k*32 +: 32] = a ^ (32'(k) * 32'h0101_0101);
    return d;
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  task automatic chkd(input string tag, input logic [DW-1:0] o, input logic [DW-1:0] e);
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask

  // One clock: sample at negedge, check holds, drive inputs, book the coming posedge handshakes.
  task automatic cycle();
    @(negedge clk);
    cyc++;
    if (!p_rst && p_rqv && !p_rqr) begin
      chk("req_hold_valid", 32'(rd_req_valid), 32'd1);
      chk("req_hold_addr", rd_req_addr, p_addr);
      chk("req_hold_len", 32'(rd_req_len), 32'(p_len));
    end
    if (!p_rst && p_dv && !p_dr) begin
      chk("out_hold_valid", 32'(ddr_valid), 32'd1);
      chkd("out_hold_data", ddr_data, p_data);
    end
    if (start_nx && (done === 1'b1) && !rst_nx) begin
      exp_base  = conf_base_addr;
      exp_total = int'(conf_beat_num) + 1;
      rcv       = 0;
      req_beats = 0;
      req_addr_log.delete();
      req_len_log.delete();
    end
    rst      = rst_nx;
    start    = start_nx;
    rst_nx   = 1'b0;
    start_nx = 1'b0;
    if (rst) begin
      cred_m = 0; exp_total = 0; rcv = 0; req_beats = 0;
      req_addr_log.delete();
      req_len_log.delete();
    end
    rd_req_ready = rq_ready_v;
    ddr_ready    = sink_ready_v;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      rd_data_valid = 1'b1;
      rd_data       = data_for(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end else begin
      rd_data_valid = 1'b0;
      rd_data       = '0;
    end
    if (!rst) begin
      if (rd_req_valid && rd_req_ready) begin
        req_addr_log.push_back(rd_req_addr);
        req_len_log.push_back(rd_req_len);
        cred_m    += int'(rd_req_len) + 1;
        req_beats += int'(rd_req_len) + 1;
        chk("credit_bound", 32'(cred_m <= 64), 32'd1);
        for (int b = 0; b <= int'(rd_req_len); b++) begin
          pend_addr.push_back(rd_req_addr + 32'(b * 64));
          pend_due.push_back(cyc + 3);
        end
      end
      if (ddr_valid && ddr_ready) begin
        chk("beat_in_range", 32'(rcv < exp_total), 32'd1);
        chkd("beat_data", ddr_data, data_for(exp_base + 32'(rcv * 64)));
        rcv++;
        cred_m--;
        last_hs_cyc = cyc;
      end
    end
    p_rst  = rst;
    p_rqv  = rd_req_valid;
    p_rqr  = rd_req_ready;
    p_addr = rd_req_addr;
    p_len  = rd_req_len;
    p_dv   = ddr_valid;
    p_dr   = ddr_ready;
    p_data = ddr_data;
  endtask

  task automatic go(input logic [31:0] base, input logic [15:0] n);
    conf_base_addr = base;
    conf_beat_num  = n;
    start_nx       = 1'b1;
    cycle();
    cycle();
    chk("busy_after_start", 32'(done), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      cycle();
      k++;
    end
    chk("done_timeout", 32'(done), 32'd1);
    chk("done_latency", 32'(cyc), 32'(last_hs_cyc + 1));
    chk("beat_count", 32'(rcv), 32'(exp_total));
  endtask

  task automatic chk_req(input string tag, input int idx, input logic [31:0] a, input logic [7:0] l);
    logic [31:0] oa;
    logic [7:0]  ol;
    oa = (idx < req_addr_log.size()) ? req_addr_log[idx] : 32'hDEAD_BEEF;
    ol = (idx < req_len_log.size())  ? req_len_log[idx]  : 8'hEE;
    chk({tag, "_addr"}, oa, a);
    chk({tag, "_len"}, 32'(ol), 32'(l));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; conf_base_addr = '0; conf_beat_num = '0;
    rd_req_ready = 1'b1; rd_data = '0; rd_data_valid = 1'b0; ddr_ready = 1'b1;

    // Reset state
    rst_nx = 1'b1; cycle();
    rst_nx = 1'b1; cycle();
    cycle();
    chk("rst_done", 32'(done), 32'd1);
    chk("rst_req_valid", 32'(rd_req_valid), 32'd0);
    chk("rst_ddr_valid", 32'(ddr_valid), 32'd0);
    chk("rst_rd_data_ready", 32'(rd_data_ready), 32'd1);

    // Aligned single burst
    go(32'h0000_1000, 16'd3);
    wait_done(200);
    chk("t1_nreq", 32'(req_addr_log.size()), 32'd1);
    chk_req("t1_req0", 0, 32'h0000_1000, 8'd3);

    // 4 KB boundary split
    go(32'h0000_0FC0, 16'd3);
    wait_done(200);
    chk("t2_nreq", 32'(req_addr_log.size()), 32'd2);
    chk_req("t2_req0", 0, 32'h0000_0FC0, 8'd0);
    chk_req("t2_req1", 1, 32'h0000_1000, 8'd2);

    // MAX_BURST split
    go(32'h0000_0000, 16'd39);
    wait_done(400);
    chk("t3_nreq", 32'(req_addr_log.size()), 32'd3);
    chk_req("t3_req0", 0, 32'h0000_0000, 8'd15);
    chk_req("t3_req1", 1, 32'h0000_0400, 8'd15);
    chk_req("t3_req2", 2, 32'h0000_0800, 8'd7);

    // Sink stalled: requests stop at the FIFO credit limit
    sink_ready_v = 1'b0;
    go(32'h0000_2000, 16'd199);
    repeat (100) cycle();
    chk("t4_stalled_req_beats", 32'(req_beats), 32'd64);
    chk("t4_stalled_done", 32'(done), 32'd0);
    sink_ready_v = 1'b1;
    wait_done(2000);

    // Request channel held off, then a start pulse while busy
    rq_ready_v = 1'b0;
    go(32'h0000_3F00, 16'd9);
    repeat (20) cycle();
    chk("t5_no_accept", 32'(req_addr_log.size()), 32'd0);
    rq_ready_v = 1'b1;
    repeat (3) cycle();
    conf_base_addr = 32'h0000_8000;
    conf_beat_num  = 16'd0;
    start_nx       = 1'b1;
    cycle();
    cycle();
    chk("t5_start_ignored", 32'(done), 32'd0);
    wait_done(400);
    chk("t5_nreq", 32'(req_addr_log.size()), 32'd2);
    chk_req("t5_req0", 0, 32'h0000_3F00, 8'd3);
    chk_req("t5_req1", 1, 32'h0000_4000, 8'd5);

    // Reset mid-transfer, stale beats arrive in IDLE, then a one-beat transfer
    go(32'h0000_6000, 16'd31);
    repeat (8) cycle();
    rst_nx = 1'b1;
    cycle();
    cycle();
    chk("t6_rst_done", 32'(done), 32'd1);
    chk("t6_rst_ddr_valid", 32'(ddr_valid), 32'd0);
    chk("t6_rst_req_valid", 32'(rd_req_valid), 32'd0);
    for (int k = 0; k < 100 && pend_addr.size() > 0; k++) cycle();
    cycle();
    cycle();
    chk("t6_stale_dropped", 32'(ddr_valid), 32'd0);
    go(32'h0000_9040, 16'd0);
    wait_done(200);
    chk("t6_nreq", 32'(req_addr_log.size()), 32'd1);
    chk_req("t6_req0", 0, 32'h0000_9040, 8'd0);
    repeat (5) cycle();
    chk("t6_idle_ddr_valid", 32'(ddr_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

endmodule
